// File: rtl/pc_sequencer.sv
// Program-counter sequencer: conditional/indirect branches, call/return through
// a circular return-address stack, stall and a terminal HALT state.
module pc_sequencer #(
  parameter int unsigned        ADDR_W    = 16,
  parameter int unsigned        IMM_W     = 9,
  parameter int unsigned        RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              branch,
  input  logic              branchreg,
  input  logic              call,
  input  logic              ret,
  input  logic [2:0]        cond,
  input  logic [2:0]        flags,
  input  logic [IMM_W-1:0]  imm,
  input  logic [ADDR_W-1:0] reg_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus2,
  output logic              flush,
  output logic              halted,
  output logic              ras_ovf,
  output logic              ras_unf
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PW-1:0]     sp_q, sp_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              flush_q, flush_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push_en;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

  logic [ADDR_W-1:0] imm_ext;
  logic [ADDR_W-1:0] rel_target;
  logic [PW-1:0]     top_idx;
  logic              cond_met;
  logic              flag_z, flag_v, flag_n;

  assign flag_z     = flags[2];
  assign flag_v     = flags[1];
  assign flag_n     = flags[0];
  assign pc_plus2   = pc_q + ADDR_W'(2);
  assign imm_ext    = ADDR_W'($signed(imm));
  assign rel_target = pc_plus2 + (imm_ext << 1);
  assign top_idx    = sp_q - PW'(1);

  always_comb begin
    cond_met = 1'b0;
    unique case (cond)
      3'd0: cond_met = ~flag_z;
      3'd1: cond_met = flag_z;
      3'd2: cond_met = ~flag_z & ~flag_n;
      3'd3: cond_met = flag_n;
      3'd4: cond_met = flag_z | (~flag_z & ~flag_n);
      3'd5: cond_met = flag_n | flag_z;
      3'd6: cond_met = flag_v;
      3'd7: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end

  // sp_q always points at the next free slot; when full it is also the oldest
  // entry, so a push there overwrites it and keeps the ring consistent.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    flush_d = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    if (state_q == S_RUN) begin
      if (halt_req) begin
        state_d = S_HALT;
      end else if (!stall) begin
        if (ret) begin
          if (cnt_q != '0) begin
            pc_d    = ras_q[top_idx];
            sp_d    = top_idx;
            cnt_d   = cnt_q - CW'(1);
            flush_d = 1'b1;
          end else begin
            pc_d  = pc_plus2;
            unf_d = 1'b1;
          end
        end else if (call) begin
          push_en = 1'b1;
          sp_d    = sp_q + PW'(1);
          pc_d    = rel_target;
          flush_d = 1'b1;
          if (cnt_q == CW'(RAS_DEPTH)) ovf_d = 1'b1;
          else                         cnt_d = cnt_q + CW'(1);
        end else if (branchreg && cond_met) begin
          pc_d    = reg_target;
          flush_d = 1'b1;
        end else if (branch && cond_met) begin
          pc_d    = rel_target;
          flush_d = 1'b1;
        end else begin
          pc_d = pc_plus2;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      sp_q    <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      if (push_en) ras_q[sp_q] <= pc_plus2;
    end
  end

  assign pc      = pc_q;
  assign flush   = flush_q;
  assign halted  = (state_q == S_HALT);
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by random control traffic,
// all compared against a queue-based reference model of the sequencer.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, halt_req = 1'b0, branch = 1'b0, branchreg = 1'b0;
  logic        call = 1'b0, ret = 1'b0;
  logic [2:0]  cond = '0, flags = '0;
  logic [8:0]  imm = '0;
  logic [15:0] reg_target = '0;
  logic [15:0] pc, pc_plus2;
  logic        flush, halted, ras_ovf, ras_unf;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [15:0] m_pc;
  logic [15:0] m_stack[$];
  logic        m_flush, m_halted, m_ovf, m_unf;
  logic [15:0] saved_pc;

  pc_sequencer #(.ADDR_W(16), .IMM_W(9), .RAS_DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .halt_req(halt_req),
    .branch(branch), .branchreg(branchreg), .call(call), .ret(ret),
    .cond(cond), .flags(flags), .imm(imm), .reg_target(reg_target),
    .pc(pc), .pc_plus2(pc_plus2), .flush(flush), .halted(halted),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit cond_true(input logic [2:0] c, input logic [2:0] f);
    bit z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000;
    m_stack.delete();
    m_flush = 0; m_halted = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_step();
    int off;
    logic [15:0] p2, rel;
    p2  = m_pc + 16'd2;
    off = imm[8] ? int'(imm) - 512 : int'(imm);
    rel = 16'((int'(p2) + 2 * off) & 32'hFFFF);
    m_flush = 0;
    if (m_halted) begin
    end else if (halt_req) begin
      m_halted = 1;
    end else if (stall) begin
    end else if (ret) begin
      if (m_stack.size() > 0) begin
        m_pc = m_stack.pop_back();
        m_flush = 1;
      end else begin
        m_pc = p2;
        m_unf = 1;
      end
    end else if (call) begin
      if (m_stack.size() == 4) begin
        void'(m_stack.pop_front());
        m_ovf = 1;
      end
      m_stack.push_back(p2);
      m_pc = rel;
      m_flush = 1;
    end else if (branchreg && cond_true(cond, flags)) begin
      m_pc = reg_target;
      m_flush = 1;
    end else if (branch && cond_true(cond, flags)) begin
      m_pc = rel;
      m_flush = 1;
    end else begin
      m_pc = p2;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},     pc,                 m_pc);
    chk({tag, ".pc2"},    pc_plus2,           m_pc + 16'd2);
    chk({tag, ".flush"},  {15'd0, flush},     {15'd0, m_flush});
    chk({tag, ".halted"}, {15'd0, halted},    {15'd0, m_halted});
    chk({tag, ".ovf"},    {15'd0, ras_ovf},   {15'd0, m_ovf});
    chk({tag, ".unf"},    {15'd0, ras_unf},   {15'd0, m_unf});
  endtask

  // Called #1 after a rising edge; applies inputs, clocks once, checks.
  task automatic step(input string tag, input logic st, input logic hr, input logic br,
                      input logic brr, input logic cl, input logic rt,
                      input logic [2:0] cd, input logic [2:0] fl,
                      input logic [8:0] im, input logic [15:0] rtg);
    stall = st; halt_req = hr; branch = br; branchreg = brr; call = cl; ret = rt;
    cond = cd; flags = fl; imm = im; reg_target = rtg;
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 9'd0, 16'h0000);
  endtask

  task automatic jump_to(input logic [15:0] tgt);
    step("jump", 0, 0, 0, 1, 0, 0, 3'd7, 3'd0, 9'd0, tgt);
  endtask

  task automatic do_reset();
    rst_n = 0;
    stall = 0; halt_req = 0; branch = 0; branchreg = 0; call = 0; ret = 0;
    model_reset();
    #2;
    check_all("reset");
    #2;
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Free-running increment after reset
    idle("run0"); chk("run0.const", pc, 16'h0002);
    idle("run1"); chk("run1.const", pc, 16'h0004);
    idle("run2"); chk("run2.const", pc, 16'h0006);

    // Conditional relative branch, taken and not taken
    jump_to(16'h0010);
    step("br_taken", 0, 0, 1, 0, 0, 0, 3'd3, 3'b001, 9'h1FE, 16'h0);
    chk("br_taken.const", pc, 16'h000E);
    chk("br_taken.flush", {15'd0, flush}, 16'd1);
    jump_to(16'h0010);
    step("br_nt", 0, 0, 1, 0, 0, 0, 3'd3, 3'b000, 9'h1FE, 16'h0);
    chk("br_nt.const", pc, 16'h0012);
    chk("br_nt.flush", {15'd0, flush}, 16'd0);

    // Call / return
    jump_to(16'h0020);
    step("call", 0, 0, 0, 0, 1, 0, 3'd0, 3'd0, 9'h010, 16'h0);
    chk("call.const", pc, 16'h0042);
    step("ret", 0, 0, 0, 0, 0, 1, 3'd0, 3'd0, 9'h000, 16'h0);
    chk("ret.const", pc, 16'h0022);

    // Stack overflow then underflow
    jump_to(16'h0100);
    for (int i = 0; i < 5; i++) step("call5", 0, 0, 0, 0, 1, 0, 3'd0, 3'd0, 9'h000, 16'h0);
    chk("ovf.const", {15'd0, ras_ovf}, 16'd1);
    for (int i = 0; i < 4; i++) begin
      step("ret4", 0, 0, 0, 0, 0, 1, 3'd0, 3'd0, 9'h000, 16'h0);
      chk("ret4.const", pc, 16'h010A - 16'(2 * i));
    end
    step("ret5", 0, 0, 0, 0, 0, 1, 3'd0, 3'd0, 9'h000, 16'h0);
    chk("ret5.const", pc, 16'h0106);
    chk("unf.const", {15'd0, ras_unf}, 16'd1);

    // Address wraparound
    do_reset();
    jump_to(16'hFFFE);
    idle("wrap");
    chk("wrap.const", pc, 16'h0000);
    jump_to(16'hFFFC);
    step("wrapbr", 0, 0, 1, 0, 0, 0, 3'd7, 3'd0, 9'h0FF, 16'h0);
    chk("wrapbr.const", pc, 16'h01FC);

    // Stall holds, halt freezes until reset
    saved_pc = m_pc;
    for (int i = 0; i < 3; i++) begin
      step("stall", 1, 0, 1, 0, 0, 0, 3'd7, 3'd0, 9'h010, 16'h0);
      chk("stall.const", pc, saved_pc);
    end
    step("halt", 1, 1, 0, 0, 0, 0, 3'd0, 3'd0, 9'h0, 16'h0);
    chk("halt.const", {15'd0, halted}, 16'd1);
    for (int i = 0; i < 3; i++) begin
      step("halted", 0, 0, 0, 0, 1, 1, 3'd7, 3'd0, 9'h020, 16'h1234);
      chk("halted.const", pc, saved_pc);
    end
    do_reset();

    // Random traffic with occasional halts and mid-run resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset();
      end else begin
        step("rand",
             $urandom_range(0, 5) == 0, $urandom_range(0, 99) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
             3'($urandom), 3'($urandom), 9'($urandom), 16'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, 16, PC and target width in bits.
REQ-002 Parameter IMM_W, 9, branch/call offset width in bits (signed, halfword units).
REQ-003 Parameter RAS_DEPTH, 4, return-address stack entries (power of two, >= 2).
REQ-004 Parameter RESET_PC, 0, PC value loaded on reset.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 stall  in  1  hold PC and all state this cycle.
REQ-008 halt_req  in  1  enter HALT.
REQ-009 branch  in  1  conditional PC-relative branch.
REQ-010 branchreg  in  1  conditional register-indirect branch.
REQ-011 call  in  1  unconditional PC-relative call, pushes return address.
REQ-012 ret  in  1  unconditional return, pops return address.
REQ-013 cond  in  3  condition code.
REQ-014 flags  in  3  {Z,V,N}: flags[2]=Z, flags[1]=V, flags[0]=N.
REQ-015 imm  in  IMM_W  signed offset.
REQ-016 reg_target  in  ADDR_W  target for branchreg.
REQ-017 pc  out  ADDR_W  current PC (registered).
REQ-018 pc_plus2  out  ADDR_W  pc+2, combinational.
REQ-019 flush  out  1  registered one-cycle pulse: redirect taken last cycle.
REQ-020 halted  out  1  high in HALT state.
REQ-021 ras_ovf  out  1  sticky: push occurred while stack full.
REQ-022 ras_unf  out  1  sticky: pop occurred while stack empty.

Function
REQ-023 States RUN and HALT; RUN->HALT on halt_req (stall ignored); HALT exits only via reset.
REQ-024 In HALT: pc, stack, sticky flags hold; flush=0; all control inputs ignored.
REQ-025 In RUN with stall=1 and halt_req=0: pc, stack and sticky flags hold; flush next cycle 0.
REQ-026 Condition met: c0 Z=0; c1 Z=1; c2 Z=0&N=0; c3 N=1; c4 Z=1|(Z=0&N=0); c5 N=1|Z=1; c6 V=1; c7 always.
REQ-027 Relative target = pc_plus2 + (sign-extended imm << 1); all sums modulo 2^ADDR_W.
REQ-028 Next-PC priority in RUN, not stalled: halt_req (pc holds) > ret > call > branchreg&cond_met > branch&cond_met > pc_plus2.
REQ-029 ret, stack non-empty: pc <= top entry, pop, flush pulse.
REQ-030 ret, stack empty: pc <= pc_plus2, ras_unf<=1, no flush, count stays 0.
REQ-031 call: push pc_plus2, pc <= relative target, flush pulse.
REQ-032 call, stack full: overwrite oldest entry (circular), count stays RAS_DEPTH, ras_ovf<=1.
REQ-033 branchreg taken: pc <= reg_target, flush pulse; branch taken: pc <= relative target, flush pulse.
REQ-034 Untaken branch/branchreg: pc <= pc_plus2, no flush.
REQ-035 Lower-priority simultaneous requests are dropped; no push/pop from them.
REQ-036 flush asserts exactly one cycle after the redirecting edge, for one cycle.

Reset
REQ-037 rst_n low asynchronously: pc=RESET_PC, state RUN, flush=0, halted=0, ras_ovf=0, ras_unf=0, stack count=0.
REQ-038 Reset mid-operation (incl. HALT, stall, pending flush) discards all state; first edge after release advances from RESET_PC.

Verification
REQ-039 Reset release, no controls, 3 cycles -> pc 0x0000,0x0002,0x0004,0x0006; flush=0.
REQ-040 pc=0x0010, branch, cond=3, imm=9'h1FE, N=1 -> pc=0x000E, flush=1 next cycle; same with N=0 -> pc=0x0012, flush=0.
REQ-041 pc=0x0020, call imm=0x010 -> pc=0x0042, top=0x0022; then ret -> pc=0x0022, flush pulse each.
REQ-042 Five calls with RAS_DEPTH=4 -> ras_ovf=1; five rets -> first four return in LIFO order, fifth gives pc_plus2, ras_unf=1.
REQ-043 stall high 3 cycles with branch taken -> pc unchanged, flush=0; halt_req during stall -> halted=1, pc frozen until rst_n low.
REQ-044 pc=0xFFFE, no control -> pc=0x0000; branch c7 imm=9'h0FF at pc=0xFFFC -> pc=0x01FC.
